moore_phase_sequencer: RTL

Parametrised Moore sequencer, the successor to the fixed 4-state output machine. It steps through NPHASE phases. Each phase drives a programmable output pattern for a programmable dwell time. Start, hold and abort controls are provided, plus a completion pulse. It is used as a generic control-sequence generator inside datapath blocks. All outputs are registered.

---
 rtl/moore_phase_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/moore_phase_sequencer.sv
// -----------------------------------------------------------------------------
// moore_phase_sequencer
//
// Purpose:
//   Parametrised Moore control-sequence generator. On start it steps through
//   NPHASE phases. Each phase drives a programmable output pattern for
//   (dwell+1) cycles. A one-cycle done pulse marks normal completion. All
//   outputs are registered, so there is no combinational path from any input
//   to any output.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over everything)
//   start_i    start request, accepted only while idle
//   hold_i     freezes counter, phase and output while running
//   abort_i    terminates a running sequence without a done pulse
//   dwell_i    per-phase dwell, phase k at [k*CNT_W +: CNT_W]
//   pattern_i  per-phase output pattern, phase k at [k*OUT_W +: OUT_W]
//   y_o        registered output pattern
//   phase_o    current phase index
//   busy_o     high while running
//   done_o     one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module moore_phase_sequencer #(
  parameter int NPHASE = 4,
  parameter int CNT_W  = 8,
  parameter int OUT_W  = 2,
  parameter int PH_W   = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      hold_i,
  input  logic                      abort_i,
  input  logic [NPHASE*CNT_W-1:0]   dwell_i,
  input  logic [NPHASE*OUT_W-1:0]   pattern_i,
  output logic [OUT_W-1:0]          y_o,
  output logic [PH_W-1:0]           phase_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NPHASE - 1);

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [OUT_W-1:0]        y_q, y_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NPHASE*CNT_W-1:0] dwell_sh_q, dwell_sh_d;
  logic [NPHASE*OUT_W-1:0] pattern_sh_q, pattern_sh_d;

  // Shadowed configuration viewed as per-phase arrays.
  logic [CNT_W-1:0] dwell_arr [NPHASE];
  logic [OUT_W-1:0] pat_arr   [NPHASE];

  genvar gi;
  generate
    for (gi = 0; gi < NPHASE; gi++) begin : g_unpack
      assign dwell_arr[gi] = dwell_sh_q[gi*CNT_W +: CNT_W];
      assign pat_arr[gi]   = pattern_sh_q[gi*OUT_W +: OUT_W];
    end
  endgenerate

  logic [PH_W-1:0] phase_inc;
  logic            dwell_hit;

  assign phase_inc = phase_q + PH_W'(1);
  // Equality compare only: the counter is cleared on a hit, so it can never
  // run past the programmed dwell.
  assign dwell_hit = (cnt_q == dwell_arr[phase_q]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    y_d          = y_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dwell_sh_d   = dwell_sh_q;
    pattern_sh_d = pattern_sh_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        phase_d = '0;
        busy_d  = 1'b0;
        y_d     = '0;
        if (start_i && !abort_i) begin
          state_d      = S_RUN;
          dwell_sh_d   = dwell_i;
          pattern_sh_d = pattern_i;
          // Drive phase 0 straight from the input; the shadow is being
          // loaded on this same edge.
          y_d          = pattern_i[0 +: OUT_W];
          busy_d       = 1'b1;
        end
      end

      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
          y_d     = '0;
          busy_d  = 1'b0;
          phase_d = '0;
          cnt_d   = '0;
        end else if (hold_i) begin
          // Everything keeps its value.
        end else if (dwell_hit) begin
          cnt_d = '0;
          if (phase_q != LAST_PH) begin
            phase_d = phase_inc;
            y_d     = pat_arr[phase_inc];
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            y_d     = '0;
            phase_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Single-cycle completion state; start and abort are ignored here.
        state_d = S_IDLE;
        y_d     = '0;
        busy_d  = 1'b0;
        phase_d = '0;
        cnt_d   = '0;
      end

      default: begin
        // Illegal encoding: recover to idle with reset output values.
        state_d = S_IDLE;
        cnt_d   = '0;
        phase_d = '0;
        y_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dwell_sh_q   <= '0;
      pattern_sh_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dwell_sh_q   <= dwell_sh_d;
      pattern_sh_q <= pattern_sh_d;
    end
  end

  assign y_o     = y_q;
  assign phase_o = phase_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
